// File: rtl/chained_adder_pkg.sv
// chained_adder_pkg: shared FSM state type and default sizing for chained_adder.
package chained_adder_pkg;
    typedef enum logic {IDLE, CHAIN} state_t;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_MAX_WORDS = 8;
endpackage

// File: rtl/chained_adder_slice.sv
// adder_slice: one-word combinational adder, {cout, sum} = a + (inv_b ? ~b : b) + cin.
// Ports: a, b (WIDTH operands), cin (carry in), inv_b (invert b for subtract),
//        sum (WIDTH result), cout (carry out).
module adder_slice
    import chained_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             inv_b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, inv_b ? ~b : b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/chained_adder.sv
// chained_adder: multi-word add (optionally subtract) chained one word per cycle with carry propagation.
// Ports: clk, reset (async, active-low), on_off (enable; 0 aborts),
//        in_valid/in_ready/a/b/last/carry_in/carry_listen (operand word in),
//        sub (subtract, only with CHAINED_ADDER_SUB_EN),
//        out_valid/out_ready/c/carry_out/out_last (registered result word out),
//        ack (final word transferring), overflow (sticky forced termination at MAX_WORDS).
// Option macro: CHAINED_ADDER_SUB_EN adds the sub port and subtract mode.
module chained_adder
    import chained_adder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_off,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             last,
    input  logic             carry_in,
    input  logic             carry_listen,
`ifdef CHAINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             out_last,
    output logic             ack,
    output logic             overflow
);
    localparam int CW = $clog2(MAX_WORDS);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             chain_c, sub_w, accept, first, forced, word_last, cin, slice_cout;
    logic [WIDTH-1:0] slice_sum;

    // in_ready is gated by reset so every output reads 0 while reset is held
    assign in_ready  = reset && on_off && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign first     = state == IDLE;
    assign forced    = !last && cnt == CW'(MAX_WORDS - 1);
    assign word_last = last || forced;
    assign ack       = out_valid && out_ready && out_last;

`ifdef CHAINED_ADDER_SUB_EN
    logic sub_q;
    // subtract mode is latched from the first word and kept for the rest of the chain
    assign sub_w = first ? sub : sub_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sub_q <= 1'b0;
        else if (!on_off) sub_q <= 1'b0;
        else if (accept && first) sub_q <= sub;
    end
`else
    assign sub_w = 1'b0;
`endif

    // a first word without carry_listen injects 0 for add, 1 for subtract (two's complement)
    assign cin = first ? (carry_listen ? carry_in : sub_w) : chain_c;

    adder_slice #(.WIDTH(WIDTH)) u_slice (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .inv_b(sub_w),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_nx = !on_off ? IDLE : accept ? (word_last ? IDLE : CHAIN) : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || !on_off) begin
            chain_c   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            c         <= '0;
            carry_out <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            chain_c   <= slice_cout;
            cnt       <= word_last ? '0 : cnt + CW'(1);
            out_valid <= 1'b1;
            c         <= slice_sum;
            carry_out <= slice_cout;
            out_last  <= word_last;
            overflow  <= overflow | forced;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_chained_adder.sv
// tb_chained_adder: scoreboard bench for chained_adder (WIDTH=16, MAX_WORDS=2) with directed vectors.
module tb_chained_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        on_off = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        last = 1'b0;
    logic        carry_in = 1'b0;
    logic        carry_listen = 1'b0;
`ifdef CHAINED_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] c;
    logic        carry_out;
    logic        out_last;
    logic        ack;
    logic        overflow;

    typedef struct packed {
        logic [15:0] c;
        logic        co;
        logic        ol;
        logic        ov;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0;

    chained_adder #(.WIDTH(16), .MAX_WORDS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .on_off      (on_off),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .last        (last),
        .carry_in    (carry_in),
        .carry_listen(carry_listen),
`ifdef CHAINED_ADDER_SUB_EN
        .sub         (sub),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .carry_out   (carry_out),
        .out_last    (out_last),
        .ack         (ack),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tl,
                        input logic tci, input logic tcl, input logic [15:0] ec,
                        input logic eco, input logic eol, input logic eov);
        bit ok = 0;
        a = ta; b = tb; last = tl; carry_in = tci; carry_listen = tcl; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for a=%h b=%h", ta, tb);
        end else begin
            @(posedge clk);
            q.push_back('{ec, eco, eol, eov});
        end
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got c=%h, expected no word", c);
            end else begin
                mon_e = q.pop_front();
                chk("c", c, mon_e.c);
                chk("carry_out", {15'd0, carry_out}, {15'd0, mon_e.co});
                chk("out_last", {15'd0, out_last}, {15'd0, mon_e.ol});
                chk("ack", {15'd0, ack}, {15'd0, mon_e.ol});
                chk("overflow", {15'd0, overflow}, {15'd0, mon_e.ov});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_c", c, 16'd0);
        chk("rst_carry_out", {15'd0, carry_out}, 16'd0);
        chk("rst_out_last", {15'd0, out_last}, 16'd0);
        chk("rst_ack", {15'd0, ack}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
        idle(1);
        reset = 1'b1;
        idle(1);

        // single word, carry_in ignored without carry_listen
        send(16'h000A, 16'h0005, 1, 1, 0, 16'h000F, 0, 1, 0);
        // two-word chain; continuation ignores carry_in/carry_listen
        send(16'hFFFF, 16'h0001, 0, 1, 0, 16'h0000, 1, 0, 0);
        send(16'h0000, 16'h0000, 1, 0, 1, 16'h0001, 0, 1, 0);

        // backpressure: held result stays stable, next word waits
        idle(2);
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1, 0, 0, 16'h2345, 0, 1, 0);
        a = 16'h0F0F; b = 16'h0101; last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
            chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_c", c, 16'h2345);
            chk("bp_ack", {15'd0, ack}, 16'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h0F0F, 16'h0101, 1, 0, 0, 16'h1010, 0, 1, 0);

        // forced termination at MAX_WORDS=2, back to back at one word per cycle
        idle(2);
        t0 = cyc;
        send(16'h0001, 16'h0001, 0, 0, 0, 16'h0002, 0, 0, 0);
        send(16'h0002, 16'h0002, 0, 0, 0, 16'h0004, 0, 1, 1);
        send(16'h0003, 16'h0003, 0, 0, 0, 16'h0006, 0, 0, 1);
        send(16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 1);
        chk("throughput_cycles", 16'(cyc - t0), 16'd4);

        // abort with on_off=0 mid-chain clears everything including sticky overflow
        idle(2);
        out_ready = 1'b0;
        send(16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1);
        on_off = 1'b0;
        idle(1);
        chk("abort_in_ready", {15'd0, in_ready}, 16'd0);
        chk("abort_out_valid", {15'd0, out_valid}, 16'd0);
        chk("abort_c", c, 16'd0);
        chk("abort_carry_out", {15'd0, carry_out}, 16'd0);
        chk("abort_out_last", {15'd0, out_last}, 16'd0);
        chk("abort_ack", {15'd0, ack}, 16'd0);
        chk("abort_overflow", {15'd0, overflow}, 16'd0);
        void'(q.pop_back());
        on_off = 1'b1;
        out_ready = 1'b1;
        send(16'h000A, 16'h0005, 1, 1, 1, 16'h0010, 0, 1, 0);

        // asynchronous reset mid-chain: next word is a first word
        idle(2);
        out_ready = 1'b0;
        send(16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 0);
        reset = 1'b0;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("arst_c", c, 16'd0);
        void'(q.pop_back());
        idle(1);
        reset = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send(16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0);

`ifdef CHAINED_ADDER_SUB_EN
        idle(1);
        sub = 1'b1;
        send(16'h0005, 16'h0007, 1, 0, 0, 16'hFFFE, 0, 1, 0);
        sub = 1'b0;
`endif

        idle(3);
        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
